// File: rtl/pipeline_buf_pkg.sv
// Pipeline stage payload types, their NOP constants and sizing helpers for pipeline_buf.
package pipeline_buf_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } decode_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd;
    logic        valid;
  } execute_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        is_load;
    logic        is_store;
    logic [4:0]  rd;
    logic        valid;
  } memory_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        we;
    logic        valid;
  } writeback_t;

  // Bubble values presented by an empty stage buffer
  localparam decode_t    decode_nop    = '{pc: 32'h0, instr: 32'h0000_0013, valid: 1'b0};
  localparam execute_t   execute_nop   = '{pc: 32'h0, op_a: 32'h0, op_b: 32'h0, rd: 5'd0, valid: 1'b0};
  localparam memory_t    memory_nop    = '{addr: 32'h0, wdata: 32'h0, is_load: 1'b0, is_store: 1'b0,
                                           rd: 5'd0, valid: 1'b0};
  localparam writeback_t writeback_nop = '{result: 32'h0, rd: 5'd0, we: 1'b0, valid: 1'b0};

  // Occupancy counter width: must hold 0..depth inclusive
  function automatic int unsigned cnt_width(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width: at least one bit even for a single-entry buffer
  function automatic int unsigned ptr_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipeline_buf_if.sv
// Handshake bundle for pipeline_buf.
//   master: upstream/downstream environment (drives in_valid, in_data, out_ready)
//   slave : the buffer (drives in_ready, out_valid, out_data, count)
interface pipeline_buf_if #(
  parameter type         T     = logic [31:0],
  parameter int unsigned DEPTH = 2
);
  import pipeline_buf_pkg::*;

  localparam int unsigned CNT_W = cnt_width(DEPTH);

  logic             in_valid;
  logic             in_ready;
  T                 in_data;
  logic             out_valid;
  logic             out_ready;
  T                 out_data;
  logic [CNT_W-1:0] count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

endinterface

// File: rtl/pipeline_buf_mem.sv
// DEPTH x T storage array for pipeline_buf; synchronous write, asynchronous read, no reset.
//   clk     : write clock
//   we_i    : write enable
//   waddr_i : write index (< DEPTH)
//   wdata_i : write payload
//   raddr_i : read index (< DEPTH)
//   rdata_o : combinational read payload
module pipeline_buf_mem
  import pipeline_buf_pkg::*;
#(
  parameter type         T     = logic [31:0],
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  T                 wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output T                 rdata_o
);

  T mem_q [DEPTH];

  // Contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pipeline_buf.sv
// Elastic pipeline stage: DEPTH-entry circular buffer with valid/ready on both
// sides, global stall/flush, optional zero-latency bypass and NOP on empty.
//   clk, reset : clock, synchronous active-high reset
//   stall      : freeze, no push and no pop
//   flush      : drop all entries and the current input
//   bus        : in_valid/in_ready/in_data, out_valid/out_ready/out_data, count
module pipeline_buf
  import pipeline_buf_pkg::*;
#(
  parameter type         T      = logic [31:0],
  parameter int unsigned DEPTH  = 2,
  parameter T            NOP    = '0,
  parameter bit          BYPASS = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  pipeline_buf_if.slave bus
);

  localparam int unsigned      CNT_W    = cnt_width(DEPTH);
  localparam int unsigned      PTR_W    = ptr_width(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  T                 rdata;

  logic empty, full, hold;
  logic bypass_c, push, pop, push_store, pop_store;

  // Explicit wrap so non-power-of-two depths stay in range
  function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign hold  = stall | flush;

  // Input presented straight through when nothing is stored
  assign bypass_c = BYPASS && empty && bus.in_valid;

  // in_ready depends only on registered count and stall/flush, never on out_ready
  assign bus.in_ready  = ~full & ~hold;
  assign bus.out_valid = (~empty | bypass_c) & ~hold;
  assign bus.out_data  = !empty   ? rdata       :
                         bypass_c ? bus.in_data : NOP;
  assign bus.count     = count_q;

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  // A bypassed entry consumed in the same cycle never touches storage
  assign push_store = push & ~(bypass_c & bus.out_ready);
  assign pop_store  = pop & ~empty;

  pipeline_buf_mem #(
    .T     (T),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (push_store),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.in_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  // Pointer/occupancy next state; flush beats everything except reset
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_store) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_store)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push_store) - CNT_W'(pop_store);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Structural safety properties
  a_no_push_full: assert property (@(posedge clk) disable iff (reset) !(push_store && full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) !(pop && empty && !bypass_c));
  a_count_range:  assert property (@(posedge clk) disable iff (reset) 32'(count_q) <= DEPTH);

endmodule

// File: tb/tb_pipeline_buf.sv
// Scoreboard bench for pipeline_buf over four configurations sharing stall/flush/reset.
module tb_pipeline_buf;

  localparam int N = 4;
  localparam int unsigned DEP  [N] = '{2, 3, 1, 5};
  localparam bit          BYP  [N] = '{1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic [31:0] NOPV [N] = '{32'h0, 32'h0000_0013, 32'h0, 32'hFFFF_FFFF};

  logic clk;
  logic reset, stall, flush;

  logic        in_valid  [N];
  logic [31:0] in_data   [N];
  logic        out_ready [N];

  logic        ir  [N];
  logic        ov  [N];
  logic [31:0] od  [N];
  logic [4:0]  cnt [N];

  int total;
  int bad;

  // Expected contents of each buffer, oldest first
  logic [31:0] sb [N][$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipeline_buf_if #(.T(logic [31:0]), .DEPTH(2)) if0 ();
  pipeline_buf_if #(.T(logic [31:0]), .DEPTH(3)) if1 ();
  pipeline_buf_if #(.T(logic [31:0]), .DEPTH(1)) if2 ();
  pipeline_buf_if #(.T(logic [31:0]), .DEPTH(5)) if3 ();

  pipeline_buf #(.T(logic [31:0]), .DEPTH(2), .NOP(32'h0), .BYPASS(1'b0)) u0 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .bus(if0));
  pipeline_buf #(.T(logic [31:0]), .DEPTH(3), .NOP(32'h0000_0013), .BYPASS(1'b0)) u1 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .bus(if1));
  pipeline_buf #(.T(logic [31:0]), .DEPTH(1), .NOP(32'h0), .BYPASS(1'b1)) u2 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .bus(if2));
  pipeline_buf #(.T(logic [31:0]), .DEPTH(5), .NOP(32'hFFFF_FFFF), .BYPASS(1'b1)) u3 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .bus(if3));

  assign if0.in_valid = in_valid[0]; assign if0.in_data = in_data[0]; assign if0.out_ready = out_ready[0];
  assign if1.in_valid = in_valid[1]; assign if1.in_data = in_data[1]; assign if1.out_ready = out_ready[1];
  assign if2.in_valid = in_valid[2]; assign if2.in_data = in_data[2]; assign if2.out_ready = out_ready[2];
  assign if3.in_valid = in_valid[3]; assign if3.in_data = in_data[3]; assign if3.out_ready = out_ready[3];

  assign ir[0] = if0.in_ready; assign ov[0] = if0.out_valid; assign od[0] = if0.out_data; assign cnt[0] = 5'(if0.count);
  assign ir[1] = if1.in_ready; assign ov[1] = if1.out_valid; assign od[1] = if1.out_data; assign cnt[1] = 5'(if1.count);
  assign ir[2] = if2.in_ready; assign ov[2] = if2.out_valid; assign od[2] = if2.out_data; assign cnt[2] = 5'(if2.count);
  assign ir[3] = if3.in_ready; assign ov[3] = if3.out_valid; assign od[3] = if3.out_data; assign cnt[3] = 5'(if3.count);

  task automatic chk(input int i, input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL dut%0d %s: got %h expected %h at %0t", i, name, act, exp, $time);
    end
  endtask

  // Control-side checks against the queue model, then record accepted inputs
  task automatic check_and_update();
    for (int i = 0; i < N; i++) begin
      int unsigned sz;
      logic        hold, byp_now, exp_ir, exp_ov;
      sz = sb[i].size();
      if (reset) begin
        sb[i].delete();
        continue;
      end
      hold    = stall | flush;
      byp_now = BYP[i] && in_valid[i] && (sz == 0);
      exp_ir  = (sz < DEP[i]) && !hold;
      exp_ov  = ((sz != 0) || byp_now) && !hold;
      chk(i, "count",     32'(cnt[i]), 32'(sz));
      chk(i, "in_ready",  32'(ir[i]),  32'(exp_ir));
      chk(i, "out_valid", 32'(ov[i]),  32'(exp_ov));
      if (sz != 0)        chk(i, "head",     od[i], sb[i][0]);
      else if (byp_now)   chk(i, "bypass",   od[i], in_data[i]);
      else                chk(i, "nop",      od[i], NOPV[i]);
      if (flush)                        sb[i].delete();
      else if (in_valid[i] && exp_ir)   sb[i].push_back(in_data[i]);
    end
  endtask

  // Monitor: every output transfer must match the oldest expected entry
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        if (ov[i] && out_ready[i]) begin
          if (sb[i].size() == 0) begin
            total++;
            bad++;
            $display("FAIL dut%0d pop_empty: got transfer of %h expected no valid output", i, od[i]);
          end else begin
            chk(i, "pop_data", od[i], sb[i].pop_front());
          end
        end
      end
    end
  end

  // Inputs already applied at posedge+1; check, then advance to next posedge+1
  task automatic cycle();
    #3;
    check_and_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic v, input logic [31:0] d, input logic r);
    for (int i = 0; i < N; i++) begin
      in_valid[i]  = v;
      in_data[i]   = d;
      out_ready[i] = r;
    end
  endtask

  task automatic ctl(input logic rs, input logic st, input logic fl);
    reset = rs;
    stall = st;
    flush = fl;
  endtask

  task automatic fill_two();
    set_all(1'b1, 32'h0000_00F1, 1'b0); cycle();
    set_all(1'b1, 32'h0000_00F2, 1'b0); cycle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    ctl(1'b1, 1'b0, 1'b0);
    set_all(1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    cycle();
    cycle();
    ctl(1'b0, 1'b0, 1'b0);
    cycle();

    // Back-to-back pushes with downstream always ready
    set_all(1'b1, 32'h11, 1'b1); cycle();
    set_all(1'b1, 32'h22, 1'b1); cycle();
    set_all(1'b1, 32'h33, 1'b1); cycle();
    set_all(1'b0, 32'h0, 1'b1);  cycle(); cycle(); cycle();

    // Fill to full with downstream blocked, then drain
    set_all(1'b1, 32'hA, 1'b0); cycle();
    set_all(1'b1, 32'hB, 1'b0); cycle();
    set_all(1'b1, 32'hC, 1'b0); cycle();
    set_all(1'b1, 32'hD, 1'b0); cycle();
    set_all(1'b0, 32'h0, 1'b1);
    repeat (6) cycle();

    // Interleaved fill/pop to wrap the write pointer
    set_all(1'b1, 32'h1, 1'b0); cycle();
    set_all(1'b1, 32'h2, 1'b0); cycle();
    set_all(1'b0, 32'h0, 1'b1); cycle();
    set_all(1'b1, 32'h3, 1'b0); cycle();
    set_all(1'b1, 32'h4, 1'b0); cycle();
    set_all(1'b0, 32'h0, 1'b1);
    repeat (6) cycle();

    // Empty-buffer bypass, consumed then blocked
    set_all(1'b1, 32'h55, 1'b1); cycle();
    set_all(1'b0, 32'h0, 1'b0);  cycle();
    set_all(1'b1, 32'h55, 1'b0); cycle();
    set_all(1'b0, 32'h0, 1'b0);  cycle();
    set_all(1'b0, 32'h0, 1'b1);  repeat (3) cycle();

    // Stall holds contents for several cycles
    fill_two();
    ctl(1'b0, 1'b1, 1'b0);
    set_all(1'b1, 32'h77, 1'b1);
    repeat (4) cycle();
    ctl(1'b0, 1'b0, 1'b0);
    set_all(1'b0, 32'h0, 1'b1);
    repeat (6) cycle();

    // Flush with stall and input, reset alone, reset with flush
    fill_two();
    ctl(1'b0, 1'b1, 1'b1); set_all(1'b1, 32'h99, 1'b1); cycle();
    ctl(1'b0, 1'b0, 1'b0); set_all(1'b0, 32'h0, 1'b0);  cycle(); cycle();
    fill_two();
    ctl(1'b1, 1'b0, 1'b0); set_all(1'b1, 32'h98, 1'b1); cycle();
    ctl(1'b0, 1'b0, 1'b0); set_all(1'b0, 32'h0, 1'b0);  cycle(); cycle();
    fill_two();
    ctl(1'b1, 1'b1, 1'b1); set_all(1'b1, 32'h97, 1'b1); cycle();
    ctl(1'b0, 1'b0, 1'b0); set_all(1'b0, 32'h0, 1'b0);  cycle(); cycle();

    // Randomized traffic, independent per configuration
    for (int c = 0; c < 3000; c++) begin
      ctl(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) == 0), ($urandom_range(0, 39) == 0));
      for (int i = 0; i < N; i++) begin
        in_valid[i]  = ($urandom_range(0, 9) < 7);
        in_data[i]   = $urandom;
        out_ready[i] = ($urandom_range(0, 9) < 6);
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_buf.md
Name: pipeline_buf

Overview:
- Parametrised elastic pipeline stage. Successor to the fixed stall/flush single-entry pipeline register between core stages.
- Holds up to DEPTH entries of type T in a circular buffer with valid/ready handshakes on both sides, plus global stall and flush.
- Optional zero-latency bypass. Empty output drives a programmable NOP.
- Allows variable-latency units (LSU, future MUL/DIV) to decouple from neighbouring stages without the hazard controller stalling the whole pipe.

Parameters:
- T, logic [31:0], payload type (pipeline package signal struct).
- DEPTH, 2, entry count; legal range 1..16. DEPTH≥2 gives full throughput.
- NOP, '0, value driven on out_data when no valid entry is presented.
- BYPASS, 0, 1 = when empty, in_data is combinationally forwarded to out_data.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- stall  input  1  freeze: no push, no pop
- flush  input  1  discard all stored entries and the current input
- in_valid  input  1  upstream offers in_data
- in_ready  output  1  buffer accepts in_data this cycle
- in_data  input  $bits(T)  upstream payload
- out_valid  output  1  out_data is a valid entry
- out_ready  input  1  downstream consumes out_data this cycle
- out_data  output  $bits(T)  head entry, bypassed input, or NOP
- count  output  $clog2(DEPTH+1)  registered occupancy

Behaviour:
- Reset (reset=1 at clk edge): rd_ptr=0, wr_ptr=0, count=0. Outputs after reset: out_valid=0, out_data=NOP, in_ready=1 (unless stall or flush is asserted). Storage contents are don't-care. Reset overrides flush and stall.
- Priority each cycle: reset > flush > stall > handshakes.
- push = in_valid & in_ready. pop = out_valid & out_ready. A transfer occurs only when both valid and ready are high. Valid must not depend on ready.
- in_ready = (count < DEPTH) & ~stall & ~flush. It depends only on registered count plus stall/flush; there is no combinational path from out_ready.
- out_valid = ((count != 0) | (BYPASS & in_valid & count == 0)) & ~stall & ~flush.
- out_data:
  - head entry if count != 0;
  - else in_data if BYPASS & in_valid;
  - else NOP.
  - Driven as described even while stall or flush is asserted; consumers use out_valid.
- Latency: BYPASS=0 gives 1 cycle from push to out_valid. BYPASS=1 with empty buffer gives 0 cycles.
- Bypass consume: if count==0 and in_valid & out_ready, the entry is not written; wr_ptr and count are unchanged.
- Pointers: wrap modulo DEPTH with explicit compare-to-(DEPTH-1). Non-power-of-two DEPTH is legal.
- count_next = count + push_stored - pop_stored. Simultaneous push and pop leave count unchanged and advance both pointers.
- Full (count==DEPTH): in_ready=0. A push in the same cycle as a pop is not accepted. With DEPTH=1, throughput is therefore 1 per 2 cycles.
- Empty with BYPASS=0: out_valid=0, out_data=NOP.
- Flush: next state is count=0 and rd_ptr=wr_ptr=0. The in-flight input is dropped. No pop occurs. Flush takes effect in one cycle regardless of stall.
- Stall: pointers, count and storage hold. A stall lasting N cycles leaves the contents bit-identical.
- Reset asserted mid-transfer: all entries are lost and the state is identical to a post-reset buffer.
- Assertions: no push when count==DEPTH; no pop when count==0 unless bypassing; count ≤ DEPTH.

Decomposition:
- pipeline package holds the stage structs used as T and each stage's NOP constant: decode_nop, execute_nop, memory_nop, writeback_nop.
- Helper function ptr_inc(ptr) is local to the module.
- One natural sub-module: pipeline_buf_mem. It is a DEPTH×T register array with write port (we, waddr, wdata) and asynchronous read port (raddr → rdata). It has no reset.
- Control (pointers, count, bypass mux) lives in pipeline_buf.

Test Plan:
1. DEPTH=2, BYPASS=0, out_ready=1. Push 0x11, 0x22, 0x33 on consecutive cycles → out_data 0x11, 0x22, 0x33 one cycle later each, in_ready stays 1, count settles at 1.
2. DEPTH=3, out_ready=0. Push 0xA, 0xB, 0xC, 0xD → count=3, in_ready=0 after the third push, 0xD not accepted. Then out_ready=1 → pops 0xA, 0xB, 0xC in order, then out_valid=0 and out_data=NOP.
3. DEPTH=3. Fill 0x1, 0x2, pop 0x1, push 0x3, 0x4, drain → order 0x2, 0x3, 0x4, with wr_ptr wrapping from 2 to 0.
4. BYPASS=1, empty, in_valid=1, in_data=0x55, out_ready=1 → same cycle out_valid=1, out_data=0x55, count stays 0. Repeat with out_ready=0 → entry stored, count=1.
5. count=2 with stall=1 for 4 cycles and in_valid=1 → in_ready=0, out_valid=0, count=2 throughout. Release stall → head popped unchanged.
6. count=2, assert flush together with in_valid=1 and stall=1 → next cycle count=0, out_valid=0, out_data=NOP. Same result with reset=1 instead of flush, and reset takes precedence when both are asserted.
